// File: rtl/pll_cen_gen_if.sv
// Configuration write channel for pll_cen_gen: request, target channel,
// new ratio and the busy flag returned during the apply cycle.
interface pll_cen_gen_if #(
    parameter int W = 16
) ();
    logic         cfg_wr;
    logic [3:0]   cfg_ch;
    logic [W-1:0] cfg_num;
    logic [W-1:0] cfg_den;
    logic         cfg_busy;

    modport master (output cfg_wr, cfg_ch, cfg_num, cfg_den, input cfg_busy);
    modport slave  (input cfg_wr, cfg_ch, cfg_num, cfg_den, output cfg_busy);
endinterface

// File: rtl/pll_cen_gen.sv
// Fractional clock-enable generator: NCH channels each pulse at NUM/DEN of
// refclk, with a PLL-like lock indicator that drops on every reconfiguration.
module pll_cen_gen #(
    parameter int             NCH         = 3,
    parameter int             W           = 16,
    parameter int             LOCK_CYCLES = 8,
    parameter logic [NCH*W-1:0] DEF_NUM   = {16'd1, 16'd1, 16'd1},
    parameter logic [NCH*W-1:0] DEF_DEN   = {16'd4, 16'd2, 16'd1}
) (
    input  logic           refclk,
    input  logic           rst,
    pll_cen_gen_if.slave   cfg,
    output logic [NCH-1:0] cen,
    output logic           locked
);
    localparam int CW = (LOCK_CYCLES < 2) ? 1 : $clog2(LOCK_CYCLES + 1);

    logic [W-1:0]  num     [NCH];
    logic [W-1:0]  den     [NCH];
    logic [W-1:0]  acc     [NCH];
    logic [W-1:0]  acc_nxt [NCH];
    logic [W:0]    sum     [NCH];
    logic [W:0]    diff    [NCH];
    logic [NCH-1:0] cen_nxt;
    logic [CW-1:0] lock_cnt;
    logic          busy;
    logic          accept;

    // A numerator above the denominator would overflow the phase, so it
    // saturates to one pulse per cycle.
    function automatic logic [W-1:0] clamp_num(input logic [W-1:0] n, input logic [W-1:0] d);
        return (n > d) ? d : n;
    endfunction

    assign accept       = cfg.cfg_wr && !busy && ({1'b0, cfg.cfg_ch} < 5'(NCH));
    assign cfg.cfg_busy = busy;

    always_comb begin
        cen_nxt = '0;
        for (int i = 0; i < NCH; i++) begin
            acc_nxt[i] = '0;
            sum[i]     = '0;
            diff[i]    = '0;
            if (den[i] != '0) begin
                sum[i]  = {1'b0, acc[i]} + {1'b0, clamp_num(num[i], den[i])};
                diff[i] = sum[i] - {1'b0, den[i]};
                if (sum[i] >= {1'b0, den[i]}) begin
                    acc_nxt[i] = diff[i][W-1:0];
                    cen_nxt[i] = 1'b1;
                end else begin
                    acc_nxt[i] = sum[i][W-1:0];
                end
            end
        end
    end

    // Register stage: ratio table, phase accumulators, enables and lock state
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                num[i] <= DEF_NUM[i*W +: W];
                den[i] <= DEF_DEN[i*W +: W];
                acc[i] <= '0;
            end
            cen      <= '0;
            locked   <= 1'b0;
            lock_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            busy <= 1'b0;
            if (accept) begin
                // Clearing every accumulator realigns all channels to a common phase.
                for (int i = 0; i < NCH; i++) begin
                    if (cfg.cfg_ch == 4'(i)) begin
                        num[i] <= cfg.cfg_num;
                        den[i] <= cfg.cfg_den;
                    end
                    acc[i] <= '0;
                end
                cen      <= '0;
                busy     <= 1'b1;
                locked   <= 1'b0;
                lock_cnt <= '0;
            end else if (!locked) begin
                for (int i = 0; i < NCH; i++) acc[i] <= '0;
                cen      <= '0;
                lock_cnt <= lock_cnt + 1'b1;
                if (lock_cnt == CW'(LOCK_CYCLES - 1)) locked <= 1'b1;
            end else begin
                for (int i = 0; i < NCH; i++) acc[i] <= acc_nxt[i];
                cen <= cen_nxt;
            end
        end
    end
endmodule

// File: doc/pll_cen_gen.md
Name: pll_cen_gen

Overview:
- Parametrised successor to the fixed-ratio PLL wrapper.
- Derives NCH independent clock-enable channels from one fast system clock, using per-channel fractional accumulators (rate = NUM/DEN of refclk).
- Ratios are reprogrammable at runtime through a write handshake, and a lock indicator mimics PLL behaviour.
- Sits between the system PLL output and the core's CPU, video and audio clock-enable consumers.

Parameters:
- NCH, 3, number of clock-enable channels (1..16).
- W, 16, width of NUM/DEN/accumulator per channel.
- LOCK_CYCLES, 8, cycles of stable configuration before locked asserts (>=1).
- DEF_NUM, {16'd1,16'd1,16'd1}, packed NCH*W reset numerators; channel 0 in the LSBs.
- DEF_DEN, {16'd4,16'd2,16'd1}, packed NCH*W reset denominators; channel 0 in the LSBs.

Ports:
- refclk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cen  out  NCH  per-channel clock-enable pulses, registered, one refclk wide each.
- locked  out  1  high when configuration is stable and the channels are running.
- cfg_wr  in  1  configuration write request.
- cfg_ch  in  4  target channel index.
- cfg_num  in  W  new numerator.
- cfg_den  in  W  new denominator.
- cfg_busy  out  1  high for the apply cycle; writes are not accepted while high.

Behaviour:
- Reset (rst=1, async):
  - cen=0, locked=0, cfg_busy=0, lock counter=0, all accumulators=0.
  - num[i]/den[i] load DEF_NUM/DEF_DEN.
- Lock sequence:
  - While locked=0, the lock counter increments each cycle.
  - locked<=1 on the edge where the counter equals LOCK_CYCLES-1, so locked is high after exactly LOCK_CYCLES edges.
  - While locked=0, accumulators are held at 0 and cen=0.
- Accumulation (per channel i, only while locked=1):
  - sum = acc + num_eff, computed W+1 bits wide.
  - If sum >= den: acc <= sum-den, cen[i] <= 1.
  - Else: acc <= sum, cen[i] <= 0.
  - Latency: first evaluation occurs on the first edge after locked rises.
- Clamping and disable:
  - num_eff = min(num, den); num > den therefore gives cen every cycle.
  - den=0 disables the channel: cen[i]=0 always, acc held at 0.
  - num=0 (with den>0) gives cen[i]=0 always.
- Config handshake:
  - A write is accepted on an edge with cfg_wr=1, cfg_busy=0 and cfg_ch<NCH.
  - On that edge: num/den of cfg_ch are updated, cfg_busy<=1, locked<=0, lock counter<=0, and all accumulators and cen are cleared on the same edge, giving a global phase resync.
  - cfg_busy drops on the next edge.
  - The relock sequence then runs: locked re-asserts LOCK_CYCLES edges after acceptance.
- Write boundary cases:
  - cfg_ch>=NCH: the write is ignored; no busy, no lock drop.
  - cfg_wr while cfg_busy=1: ignored; the requester must hold cfg_wr until it sees cfg_busy=0.
  - A new accepted write during relock restarts the lock counter from 0.
- Reset mid-operation:
  - Asynchronous reset restores DEF_* ratios; any runtime configuration is lost.
  - The lock sequence restarts after rst deasserts.

Test Plan:
1. Defaults, LOCK_CYCLES=8, release rst:
   - locked=0 for edges 1..7, locked=1 after edge 8.
   - cen[0]=1 every cycle from edge 9.
   - cen[1] first at edge 10, period 2.
   - cen[2] first at edge 12, period 4.
2. Fractional ratio: write ch0 num=3 den=8, then wait for relock.
   - Per 8-cycle window after relock, cen[0] fires on cycles 3, 6 and 8.
   - Exactly 3 pulses per 8 cycles, sustained over 800 cycles (300 pulses).
3. Boundaries:
   - Write ch1 num=5 den=2: cen[1] is continuously 1 after relock.
   - Write ch2 den=0: cen[2] stays 0.
   - Write cfg_ch=7: no cfg_busy and locked stays 1.
4. Handshake collision and relock restart:
   - Assert cfg_wr on two consecutive cycles: only the first is accepted and cfg_busy is high for exactly one cycle.
   - Hold cfg_wr into the third cycle: the second write is accepted and the relock count restarts from that edge.
5. Phase resync:
   - With ch1=1/2 and ch2=1/4 running, perform any valid write.
   - After relock, cen[1] and cen[2] first pulse at +2 and +4 edges past locked, aligned as in scenario 1.
6. Reset mid-operation:
   - Assert rst asynchronously between edges while locked=1 after a runtime reprogram: cen and locked fall immediately.
   - After release, default ratios resume with the scenario-1 timing.
